// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle control unit with an 8-entry register file.
// Each instruction walks IDLE -> FETCH -> EXEC -> WB. The unit drives
// registered operands to an external combinational ALU, captures the result,
// writes it back and publishes the written value for the display stage.
module unidade_controle #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_res,
  output logic              done,
  output logic [DATA_W-1:0] disp_val,
  output logic [2:0]        disp_reg
);

  // Opcode map
  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SUBI = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_DPL  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    WB    = 2'd3
  } state_t;

  state_t            state;
  logic [15:0]       instr_q;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] regs [8];

  // Fields of the latched instruction; rs2 and imm share the low bits.
  logic [2:0]        op_q;
  logic [2:0]        rd_q;
  logic [2:0]        rs1_q;
  logic [2:0]        rs2_q;
  logic [6:0]        imm_q;
  logic [DATA_W-1:0] imm_ext;

  assign op_q  = instr_q[15:13];
  assign rd_q  = instr_q[12:10];
  assign rs1_q = instr_q[9:7];
  assign rs2_q = instr_q[6:4];
  assign imm_q = instr_q[6:0];

  // Immediates are 7 bits wide and always sign-extended to the operand width.
  assign imm_ext = {{(DATA_W-7){imm_q[6]}}, imm_q};

  // Opcodes that actually use the ALU (ADD..MUL) versus the register-register ones.
  logic is_alu;
  logic uses_rs2;
  logic wr_en;
  logic clr_all;

  assign is_alu   = (op_q >= OP_ADD) && (op_q <= OP_MUL);
  assign uses_rs2 = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_MUL);

  // Write-back only happens in WB; DPL writes nothing, CLR wipes everything.
  assign wr_en   = (state == WB) && (op_q != OP_CLR) && (op_q != OP_DPL);
  assign clr_all = (state == WB) && (op_q == OP_CLR);

  // Register file: cleared by reset or CLR, otherwise single write port at WB.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_all) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[rd_q] <= res_q;
    end
  end

  // Main sequencer: handshake, operand drive, result capture and write-back publish.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr_q     <= '0;
      instr_ready <= 1'b1;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= OP_LOAD;
      res_q       <= '0;
      done        <= 1'b0;
      disp_val    <= '0;
      disp_reg    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // instr_ready is high exactly while in IDLE, so valid alone accepts.
          if (instr_valid) begin
            instr_q     <= instr;
            instr_ready <= 1'b0;
            state       <= FETCH;
          end
        end
        FETCH: begin
          alu_a  <= regs[rs1_q];
          alu_b  <= uses_rs2 ? regs[rs2_q] : imm_ext;
          alu_op <= is_alu ? op_q : OP_LOAD;
          state  <= EXEC;
        end
        EXEC: begin
          if (is_alu) begin
            res_q <= alu_res;
          end else if (op_q == OP_LOAD) begin
            res_q <= imm_ext;
          end else if (op_q == OP_DPL) begin
            res_q <= regs[rd_q];
          end else begin
            res_q <= '0;
          end
          state <= WB;
        end
        WB: begin
          disp_val    <= res_q;
          disp_reg    <= (op_q == OP_CLR) ? 3'd0 : rd_q;
          done        <= 1'b1;
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state       <= IDLE;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Testbench for unidade_controle: table of instructions with hand-computed
// results, plus hand-written handshake and mid-instruction reset sequences.
module tb_unidade_controle;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic [7:0]  alu_res;
  logic        done;
  logic [7:0]  disp_val;
  logic [2:0]  disp_reg;

  int checks = 0;
  int errors = 0;

  logic [7:0] cap_a;
  logic [7:0] cap_b;
  logic [2:0] cap_op;

  unidade_controle #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_res    (alu_res),
    .done       (done),
    .disp_val   (disp_val),
    .disp_reg   (disp_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU seen by the unit
  logic [15:0] prod;
  always_comb begin
    prod    = 16'(alu_a) * 16'(alu_b);
    alu_res = 8'h00;
    case (alu_op)
      3'b001:  alu_res = alu_a + alu_b;
      3'b010:  alu_res = alu_a + alu_b;
      3'b011:  alu_res = alu_a - alu_b;
      3'b100:  alu_res = alu_a - alu_b;
      3'b101:  alu_res = prod[7:0];
      default: alu_res = 8'h00;
    endcase
  end

  typedef struct {
    logic [15:0] ins;
    logic [7:0]  exp_val;
    logic [2:0]  exp_reg;
    bit          chk_alu;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [2:0]  exp_op;
    string       name;
  } vec_t;

  vec_t vecs [18];

  function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 4'b0000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [6:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one instruction, return accept-to-done latency in edges (0 = timeout).
  task automatic run_instr(input logic [15:0] i, output int lat);
    int n;
    bit seen;
    n = 0;
    while (!instr_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_issue", 32'(instr_ready), 32'd1);
    instr       = i;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (!seen) begin
        @(posedge clk);
        #1;
        if (k == 1) begin
          cap_a  = alu_a;
          cap_b  = alu_b;
          cap_op = alu_op;
        end
        if (done) begin
          lat  = k;
          seen = 1'b1;
        end
      end
    end
  endtask

  task automatic apply_vec(input int idx);
    int lat;
    run_instr(vecs[idx].ins, lat);
    $display("txn %-16s instr=%04h lat=%0d disp_reg=%0d disp_val=%02h",
             vecs[idx].name, vecs[idx].ins, lat, disp_reg, disp_val);
    check({vecs[idx].name, " latency"}, 32'(lat), 32'd3);
    check({vecs[idx].name, " disp_val"}, 32'(disp_val), 32'(vecs[idx].exp_val));
    check({vecs[idx].name, " disp_reg"}, 32'(disp_reg), 32'(vecs[idx].exp_reg));
    if (vecs[idx].chk_alu) begin
      check({vecs[idx].name, " alu_a"}, 32'(cap_a), 32'(vecs[idx].exp_a));
      check({vecs[idx].name, " alu_b"}, 32'(cap_b), 32'(vecs[idx].exp_b));
      check({vecs[idx].name, " alu_op"}, 32'(cap_op), 32'(vecs[idx].exp_op));
    end
  endtask

  task automatic set_vec(input int idx, input string nm, input logic [15:0] ins,
                         input logic [7:0] ev, input logic [2:0] er, input bit ca,
                         input logic [7:0] ea, input logic [7:0] eb, input logic [2:0] eo);
    vecs[idx].name    = nm;
    vecs[idx].ins     = ins;
    vecs[idx].exp_val = ev;
    vecs[idx].exp_reg = er;
    vecs[idx].chk_alu = ca;
    vecs[idx].exp_a   = ea;
    vecs[idx].exp_b   = eb;
    vecs[idx].exp_op  = eo;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    bit exp_done;
    // Vector table: instruction, expected disp_val/disp_reg, optional ALU drive
    set_vec(0,  "LOAD r1,5",     enc_i(3'd0, 3'd1, 3'd0, 7'd5),    8'h05, 3'd1, 1'b1, 8'h00, 8'h05, 3'd0);
    set_vec(1,  "LOAD r2,3",     enc_i(3'd0, 3'd2, 3'd0, 7'd3),    8'h03, 3'd2, 1'b0, 8'h00, 8'h00, 3'd0);
    set_vec(2,  "ADD r3,r1,r2",  enc_r(3'd1, 3'd3, 3'd1, 3'd2),    8'h08, 3'd3, 1'b1, 8'h05, 8'h03, 3'd1);
    set_vec(3,  "SUBI r4,r1,7",  enc_i(3'd4, 3'd4, 3'd1, 7'd7),    8'hFE, 3'd4, 1'b1, 8'h05, 8'h07, 3'd4);
    set_vec(4,  "ADDI r5,r1,-1", enc_i(3'd2, 3'd5, 3'd1, 7'h7F),   8'h04, 3'd5, 1'b1, 8'h05, 8'hFF, 3'd2);
    set_vec(5,  "LOAD r1,20",    enc_i(3'd0, 3'd1, 3'd0, 7'd20),   8'h14, 3'd1, 1'b0, 8'h00, 8'h00, 3'd0);
    set_vec(6,  "LOAD r2,13",    enc_i(3'd0, 3'd2, 3'd0, 7'd13),   8'h0D, 3'd2, 1'b0, 8'h00, 8'h00, 3'd0);
    set_vec(7,  "MUL r6,r1,r2",  enc_r(3'd5, 3'd6, 3'd1, 3'd2),    8'h04, 3'd6, 1'b1, 8'h14, 8'h0D, 3'd5);
    set_vec(8,  "LOAD r7,-64",   enc_i(3'd0, 3'd7, 3'd0, 7'h40),   8'hC0, 3'd7, 1'b0, 8'h00, 8'h00, 3'd0);
    set_vec(9,  "DPL r4",        enc_r(3'd7, 3'd4, 3'd0, 3'd0),    8'hFE, 3'd4, 1'b1, 8'h00, 8'h00, 3'd0);
    set_vec(10, "SUB r0,r2,r1",  enc_r(3'd3, 3'd0, 3'd2, 3'd1),    8'hF9, 3'd0, 1'b1, 8'h0D, 8'h14, 3'd3);
    set_vec(11, "DPL r0",        enc_r(3'd7, 3'd0, 3'd0, 3'd0),    8'hF9, 3'd0, 1'b0, 8'h00, 8'h00, 3'd0);
    set_vec(12, "LOAD r3,9",     enc_i(3'd0, 3'd3, 3'd0, 7'd9),    8'h09, 3'd3, 1'b0, 8'h00, 8'h00, 3'd0);
    set_vec(13, "DPL r3 post",   enc_r(3'd7, 3'd3, 3'd0, 3'd0),    8'h00, 3'd3, 1'b0, 8'h00, 8'h00, 3'd0);
    set_vec(14, "LOAD r2,7",     enc_i(3'd0, 3'd2, 3'd0, 7'd7),    8'h07, 3'd2, 1'b0, 8'h00, 8'h00, 3'd0);
    set_vec(15, "CLR",           enc_r(3'd6, 3'd5, 3'd2, 3'd0),    8'h00, 3'd0, 1'b1, 8'h07, 8'h00, 3'd0);
    set_vec(16, "DPL r2",        enc_r(3'd7, 3'd2, 3'd0, 3'd0),    8'h00, 3'd2, 1'b0, 8'h00, 8'h00, 3'd0);
    set_vec(17, "DPL r1",        enc_r(3'd7, 3'd1, 3'd0, 3'd0),    8'h00, 3'd1, 1'b0, 8'h00, 8'h00, 3'd0);

    // Reset and reset-state checks
    rst_n       = 1'b0;
    instr       = 16'h0000;
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst instr_ready", 32'(instr_ready), 32'd1);
    check("rst done", 32'(done), 32'd0);
    check("rst alu_a", 32'(alu_a), 32'd0);
    check("rst alu_b", 32'(alu_b), 32'd0);
    check("rst alu_op", 32'(alu_op), 32'd0);
    check("rst disp_val", 32'(disp_val), 32'd0);
    check("rst disp_reg", 32'(disp_reg), 32'd0);

    for (int v = 0; v <= 12; v++) apply_vec(v);

    // Handshake: instr_valid held high, instr changes every cycle
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k <= 8; k++) begin
      exp_done = (k > 0) && (k % 4 == 0);
      check($sformatf("hs ready k=%0d", k), 32'(instr_ready), 32'((k % 4) == 0));
      check($sformatf("hs done k=%0d", k), 32'(done), 32'(exp_done));
      if (exp_done) begin
        check($sformatf("hs disp_val k=%0d", k), 32'(disp_val), 32'(k - 3));
        $display("txn handshake k=%0d disp_reg=%0d disp_val=%02h", k, disp_reg, disp_val);
      end
      instr       = enc_i(3'd0, 3'd5, 3'd0, 7'(k + 1));
      instr_valid = 1'b1;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    cnt = 0;
    while (!done && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("hs third done", 32'(done), 32'd1);
    check("hs third disp_val", 32'(disp_val), 32'd9);
    check("hs third disp_reg", 32'(disp_reg), 32'd5);
    $display("txn handshake last disp_reg=%0d disp_val=%02h", disp_reg, disp_val);

    // Reset during EXEC of ADD r3,r1,r2 (r3 holds 9)
    instr       = enc_r(3'd1, 3'd3, 3'd1, 3'd2);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst done", 32'(done), 32'd0);
    check("midrst ready", 32'(instr_ready), 32'd1);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("midrst no done c%0d", k), 32'(done), 32'd0);
      check($sformatf("midrst ready c%0d", k), 32'(instr_ready), 32'd1);
    end
    $display("txn reset during EXEC done=%0d instr_ready=%0d", done, instr_ready);

    for (int v = 13; v <= 17; v++) apply_vec(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multi-cycle control unit with an integrated 8×DATA_W register file that sits directly upstream of the ALU. It accepts one 16-bit instruction per handshake and reads the source registers. It drives the ALU operands and opcode, captures the ALU result, writes it back to the destination register and publishes the written value for the display stage.

## Interface

- DATA_W, 8, register/ALU operand width; immediates are always 7 bits, sign-extended to DATA_W
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous reset, active-low
- instr  input  16  instruction: [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [6:0] imm (rs2/imm overlap)
- instr_valid  input  1  instr is valid this cycle
- instr_ready  output  1  unit can accept an instruction
- alu_a  output  DATA_W  ALU operand A (registered)
- alu_b  output  DATA_W  ALU operand B (registered)
- alu_op  output  3  ALU opcode (registered)
- alu_res  input  DATA_W  combinational ALU result for alu_a/alu_b/alu_op
- done  output  1  one-cycle pulse: instruction retired
- disp_val  output  DATA_W  last written (or displayed) value
- disp_reg  output  3  register index associated with disp_val

## Operation

- Opcodes:
  - 000 LOAD: rd <- sext(imm)
  - 001 ADD: rd <- rs1+rs2
  - 010 ADDI: rd <- rs1+sext(imm)
  - 011 SUB: rd <- rs1-rs2
  - 100 SUBI: rd <- rs1-sext(imm)
  - 101 MUL: rd <- low DATA_W bits of rs1*rs2
  - 110 CLR: all registers <- 0
  - 111 DPL: no write; disp_val <- reg[rd]
- All arithmetic is modulo 2^DATA_W. Results wrap with no flag.
- All 8 registers are writable; there is no hardwired zero.
- FSM states: IDLE -> FETCH -> EXEC -> WB -> IDLE. No other transitions exist.
  - IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr and go to FETCH. Otherwise stay.
  - FETCH: alu_a <= reg[rs1]. alu_b <= reg[rs2] for ADD/SUB/MUL, else sext(imm). alu_op <= op for 001–101, else 000. Go to EXEC.
  - EXEC: res_q <= alu_res for 001–101, sext(imm) for LOAD, reg[rd] for DPL, 0 for CLR. Go to WB.
  - WB: perform the write (none for DPL; all registers for CLR). disp_val <= res_q. disp_reg <= rd (0 for CLR). Pulse done. Go to IDLE.
- instr_ready=0 in FETCH/EXEC/WB. instr_valid is ignored in those states, and no instruction is dropped or queued.
- No hazards exist: write-back completes before the next FETCH.

## Timing

- Reset (rst_n low at a rising edge) forces:
  - state=IDLE
  - all registers=0
  - alu_a=alu_b=0, alu_op=000
  - done=0
  - disp_val=0, disp_reg=0
  - instr_ready=1 in the first cycle after reset deasserts
- Reset mid-instruction discards the in-flight instruction: no write occurs and no done pulse is issued.
- Accept at edge E0. Edge E1 registers the ALU drive, and alu_res is sampled at edge E2.
- Edge E3 performs the register write and raises done, disp_val and disp_reg together. done is high for exactly the cycle after E3.
- instr_ready rises again after E3, in the same cycle as done. A new instruction can be accepted at edge E4.
- Throughput is one instruction per 4 cycles. Latency from accept to done is 3 edges.
- alu_a/alu_b/alu_op hold their values from FETCH until the next FETCH.

## Test plan

- Reset, then LOAD r1,5; LOAD r2,3; ADD r3,r1,r2 -> done pulses 3 edges after each accept. Final disp_reg=3 and disp_val=8. During ADD EXEC: alu_a=5, alu_b=3, alu_op=001.
- With r1=5: SUBI r4,r1,7 -> disp_val=0xFE. ADDI r5,r1,-1 (imm=0x7F) -> disp_val=4.
- LOAD r1,20; LOAD r2,13; MUL r6,r1,r2 -> disp_val=0x04 (260 mod 256). LOAD r7,-64 (imm=0x40) -> disp_val=0xC0.
- Handshake: hold instr_valid high continuously with different instrs -> accepts occur only on IDLE cycles, spaced 4 cycles apart. Changes to instr while busy have no effect.
- Reset during EXEC of ADD r3 (r3 previously 9) -> no done pulse. Afterwards r3=0 (DPL r3 gives disp_val=0, disp_reg=3) and instr_ready=1 one cycle after rst_n returns high.
- LOAD r2,7; CLR -> disp_val=0, disp_reg=0. DPL r2 -> disp_val=0, disp_reg=2, and no register changes.
